enigma_rotor_stage: RTL and testbench
=====================================

Name: enigma_rotor_stage

Overview:
Parametrised, registered Enigma rotor stage that replaces the fixed, stateless per-rotor lookup blocks. It holds its own position and ring setting and selects one of several wiring tables at configuration time. It translates symbols in the forward direction (keyboard to reflector) or reverse direction (reflector to lamp) through a valid/ready handshake. It steps on a carry input and generates a notch carry for the next stage. Stages are chained in the top-level datapath; ASCII/index conversion lives outside this block.

Parameters:
N_SYM, 26, alphabet size; symbols are indices 0..N_SYM-1.
SYM_W, 5, symbol/position width; must satisfy 2**SYM_W >= N_SYM.
DEFAULT_SEL, 0, wiring table selected out of reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cfg_load  in  1  one-cycle pulse; latch cfg_* fields
cfg_sel  in  3  wiring select: 0..4 = rotor I..V, other values = identity wiring
cfg_pos  in  SYM_W  start position
cfg_ring  in  SYM_W  ring setting
step_in  in  1  advance position by one; one pulse per keypress or carry
step_out  out  1  registered carry pulse to the next stage
in_valid  in  1  input symbol valid
in_ready  out  1  stage can accept a symbol
in_dir  in  1  0 = forward wiring, 1 = inverse wiring
in_sym  in  SYM_W  input symbol index
out_valid  out  1  output symbol valid
out_ready  in  1  downstream accepts
out_sym  out  SYM_W  translated symbol
out_err  out  1  in_sym was >= N_SYM; qualified by out_valid
pos  out  SYM_W  current rotor position
cfg_err  out  1  sticky flag; last cfg_load carried cfg_sel > 4 or cfg_pos/cfg_ring >= N_SYM

Behaviour:
- Reset values:
  - pos = 0, ring = 0, sel = DEFAULT_SEL.
  - step_out = 0, out_valid = 0, out_sym = 0, out_err = 0, cfg_err = 0.
  - in_ready = 1 once rst is low.
- Config load:
  - cfg_load has priority over step_in in the same cycle; the step is dropped.
  - On the cfg_load edge: pos <= cfg_pos, ring <= cfg_ring, sel <= cfg_sel.
  - Out-of-range cfg_pos/cfg_ring are loaded as 0 and set cfg_err.
  - cfg_sel > 4 loads identity wiring and sets cfg_err.
  - cfg_err clears on the next error-free cfg_load.
  - in_ready = 0 during any cycle in which cfg_load = 1.
- Stepping:
  - On step_in: pos <= (pos == N_SYM-1) ? 0 : pos + 1.
  - step_out = 1 for exactly one cycle, the cycle after a step taken while pos == notch[sel].
  - Notches: I=Q(16), II=E(4), III=V(21), IV=J(9), V=Z(25), identity = none.
  - Double-stepping is not handled here; the top level owns it.
- Translation:
  - pe = pos_next, the position after any same-cycle step.
  - Shift: s = (in_sym + pe - ring) mod N_SYM.
  - Lookup: w = W[sel][s] when in_dir = 0, Winv[sel][s] when in_dir = 1.
  - Unshift: out = (w - pe + ring) mod N_SYM.
  - Mod arithmetic uses SYM_W+2-bit intermediates with conditional add/subtract of N_SYM; no divider.
- Handshake:
  - One output register. Latency is 1 cycle (input accept edge to out_valid).
  - in_ready = !out_valid || out_ready, so a full-throughput skid-free pipe.
  - Transfer on in_valid && in_ready.
  - out_sym/out_err hold stable while out_valid && !out_ready.
- Invalid symbol (in_sym >= N_SYM): out_sym = in_sym passed unchanged, out_err = 1; position is unaffected.
- Asynchronous reset mid-transfer: the output register clears immediately and any pending data is lost.

Decomposition:
- Package enigma_pkg:
  - N_SYM_DEFAULT.
  - Wiring tables for rotors I–V as constant arrays, with their inverses.
  - Notch constants.
  - Direction enum FWD/REV.
  - Function mod_add(a,b,n), shared with the reflector and plugboard blocks.
- Sub-module enigma_wiring_lut: combinational table lookup with inputs (sel, dir, idx) and output wired symbol. It is reused by the reflector stage.

Test Plan:
- Forward, base setting: reset, cfg_load sel=0 pos=0 ring=0, step_in pulse, then forward in_sym=0 -> pos=1, out_sym=9 (J) one cycle after accept.
- Ring setting: cfg sel=0 pos=0 ring=1, no step, forward in_sym=0 -> out_sym=10 (K); reverse in_sym=10 with same setting -> out_sym=0.
- Notch carry and wrap: sel=0 pos=16, step -> pos=17, step_out high exactly one cycle. Then load pos=25, step -> pos=0, step_out stays 0. sel=4 pos=25, step -> pos=0, step_out=1.
- Backpressure: hold out_ready=0, send symbols 3 then 4 -> in_ready drops after the first accept and out_sym stays stable on 3's result; release -> 4's result follows on the next cycle, none lost or duplicated.
- Conflict and errors: cfg_load and step_in in the same cycle -> pos=cfg_pos with no step. cfg_sel=6 -> cfg_err=1 and identity mapping at pos=0/ring=0. in_sym=30 -> out_sym=30, out_err=1.
- Async reset: assert rst mid-stream with out_valid=1 -> out_valid, step_out, and pos go to 0 without a clock edge; first symbol after release is translated with sel=DEFAULT_SEL.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: constants shared by the Enigma datapath blocks.
//   N_SYM_DEFAULT      alphabet size (26)
//   ROTOR_FWD/INV      rotor I..V wirings, A=0, plus their inverses
//   NOTCH              turnover position of each rotor
//   dir_e              FWD (keyboard->reflector) / REV (reflector->lamp)
//   mod_add            (a + b) mod n for a, b < n, no divider
package enigma_pkg;

    localparam int N_SYM_DEFAULT = 26;
    localparam int N_ROTORS      = 5;
    localparam int TBL_W         = 5;
    localparam int MOD_W         = 8;

    typedef logic [TBL_W-1:0] tsym_t;
    typedef tsym_t [0:N_SYM_DEFAULT-1] wiring_t;

    typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_e;

    // Rotor I..V, entry i = contact reached from contact i.
    localparam wiring_t ROTOR_FWD [N_ROTORS] = '{
        '{5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
          5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9},
        '{5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
          5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4},
        '{5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
          5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14},
        '{5'd4,  5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9,  5'd0,  5'd24, 5'd16, 5'd20, 5'd8,  5'd17,
          5'd7,  5'd23, 5'd11, 5'd13, 5'd5,  5'd19, 5'd6,  5'd10, 5'd3,  5'd2,  5'd12, 5'd22, 5'd1},
        '{5'd21, 5'd25, 5'd1,  5'd17, 5'd6,  5'd8,  5'd19, 5'd24, 5'd20, 5'd15, 5'd18, 5'd3,  5'd13,
          5'd7,  5'd11, 5'd23, 5'd0,  5'd22, 5'd12, 5'd16, 5'd9,  5'd2,  5'd5,  5'd4,  5'd14, 5'd10}
    };

    function automatic wiring_t invert(input wiring_t w);
        wiring_t r;
        r = '0;
        for (int i = 0; i < N_SYM_DEFAULT; i++) r[w[i]] = tsym_t'(i);
        return r;
    endfunction

    // Inverses are derived at elaboration so they can never drift from ROTOR_FWD.
    localparam wiring_t ROTOR_INV [N_ROTORS] = '{
        invert(ROTOR_FWD[0]), invert(ROTOR_FWD[1]), invert(ROTOR_FWD[2]),
        invert(ROTOR_FWD[3]), invert(ROTOR_FWD[4])
    };

    // Q, E, V, J, Z
    localparam tsym_t NOTCH [N_ROTORS] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

    function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                                 input logic [MOD_W-1:0] b,
                                                 input logic [MOD_W-1:0] n);
        logic [MOD_W-1:0] s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/enigma_wiring_lut.sv
// enigma_wiring_lut: combinational wiring table lookup (also used by the reflector).
//   sel_i  wiring select, 0..4 = rotor I..V, anything else = identity
//   dir_i  FWD uses the wiring, REV its inverse
//   idx_i  contact index
//   sym_o  wired contact; indices outside the 26-entry tables pass through
module enigma_wiring_lut
    import enigma_pkg::*;
#(
    parameter int SYM_W = 5
) (
    input  logic [2:0]       sel_i,
    input  dir_e             dir_i,
    input  logic [SYM_W-1:0] idx_i,
    output logic [SYM_W-1:0] sym_o
);

    always_comb begin
        sym_o = idx_i;
        if (sel_i < 3'(N_ROTORS) && idx_i < SYM_W'(N_SYM_DEFAULT)) begin
            if (dir_i == FWD) sym_o = SYM_W'(ROTOR_FWD[sel_i][idx_i[TBL_W-1:0]]);
            else              sym_o = SYM_W'(ROTOR_INV[sel_i][idx_i[TBL_W-1:0]]);
        end
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: registered rotor with its own position/ring/wiring select.
//   clk, rst                        clock, async active-high reset
//   cfg_load/cfg_sel/cfg_pos/cfg_ring  one-cycle configuration load (wins over step_in)
//   step_in / step_out               advance request / registered notch carry
//   in_valid/in_ready/in_dir/in_sym  symbol input handshake
//   out_valid/out_ready/out_sym/out_err  registered output, 1-cycle latency
//   pos                              current position
//   cfg_err                          sticky until an error-free cfg_load
// Rotor tables are 26-symbol; other N_SYM values only make sense with identity wiring.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int         N_SYM       = N_SYM_DEFAULT,
    parameter int         SYM_W       = 5,
    parameter logic [2:0] DEFAULT_SEL = 3'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [2:0]       cfg_sel,
    input  logic [SYM_W-1:0] cfg_pos,
    input  logic [SYM_W-1:0] cfg_ring,
    input  logic             step_in,
    output logic             step_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [SYM_W-1:0] in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_err,
    output logic [SYM_W-1:0] pos,
    output logic             cfg_err
);

    localparam int               W2   = SYM_W + 2;
    localparam logic [W2-1:0]    NW   = W2'(N_SYM);
    localparam logic [SYM_W-1:0] LAST = SYM_W'(N_SYM - 1);

    logic [SYM_W-1:0] pos_q, pos_d, ring_q, ring_d;
    logic [2:0]       sel_q, sel_d;
    logic             step_out_q, step_out_d;
    logic             cfg_err_q, cfg_err_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic             out_err_q, out_err_d;

    logic             at_notch, xfer, sym_bad;
    logic [SYM_W-1:0] s_idx, lut_sym, xlat_sym;

    function automatic logic in_rng(input logic [SYM_W-1:0] v);
        return {2'b00, v} < NW;
    endfunction

    // Operands are always < 2*N_SYM, so one conditional subtract is a full mod.
    function automatic logic [SYM_W-1:0] wrap(input logic [W2-1:0] v);
        return (v >= NW) ? SYM_W'(v - NW) : SYM_W'(v);
    endfunction

    always_comb begin
        at_notch = 1'b0;
        if (sel_q < 3'(N_ROTORS)) at_notch = (pos_q == SYM_W'(NOTCH[sel_q]));
    end

    // Position/config next state; a step coinciding with cfg_load is dropped.
    always_comb begin
        pos_d      = pos_q;
        ring_d     = ring_q;
        sel_d      = sel_q;
        cfg_err_d  = cfg_err_q;
        step_out_d = 1'b0;
        if (cfg_load) begin
            pos_d     = in_rng(cfg_pos)  ? cfg_pos  : '0;
            ring_d    = in_rng(cfg_ring) ? cfg_ring : '0;
            sel_d     = cfg_sel;
            cfg_err_d = !in_rng(cfg_pos) || !in_rng(cfg_ring) || (cfg_sel >= 3'(N_ROTORS));
        end else if (step_in) begin
            pos_d      = (pos_q == LAST) ? '0 : pos_q + SYM_W'(1);
            step_out_d = at_notch;
        end
    end

    // Translate against the post-step position so a keypress step and its
    // symbol can arrive in the same cycle.
    always_comb begin
        s_idx = wrap({2'b00, wrap({2'b00, in_sym} + {2'b00, pos_d})} + (NW - {2'b00, ring_q}));
    end

    enigma_wiring_lut #(.SYM_W(SYM_W)) u_lut (
        .sel_i (sel_q),
        .dir_i (dir_e'(in_dir)),
        .idx_i (s_idx),
        .sym_o (lut_sym)
    );

    always_comb begin
        xlat_sym = wrap({2'b00, wrap({2'b00, lut_sym} + (NW - {2'b00, pos_d}))} + {2'b00, ring_q});
    end

    assign sym_bad  = !in_rng(in_sym);
    assign in_ready = !rst && !cfg_load && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_err_d   = out_err_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_sym_d   = sym_bad ? in_sym : xlat_sym;
            out_err_d   = sym_bad;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            ring_q      <= '0;
            sel_q       <= DEFAULT_SEL;
            step_out_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            ring_q      <= ring_d;
            sel_q       <= sel_d;
            step_out_q  <= step_out_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_err_q   <= out_err_d;
        end
    end

    assign step_out  = step_out_q;
    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_err   = out_err_q;
    assign pos       = pos_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Bench for enigma_rotor_stage: directed vector table, hand-written corner
// sequences, then random traffic against a letter-string reference model.
module tb_enigma_rotor_stage;

    logic       clk, rst;
    logic       cfg_load;
    logic [2:0] cfg_sel;
    logic [4:0] cfg_pos, cfg_ring;
    logic       step_in, step_out;
    logic       in_valid, in_ready, in_dir;
    logic [4:0] in_sym;
    logic       out_valid, out_ready;
    logic [4:0] out_sym;
    logic       out_err;
    logic [4:0] pos;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    enigma_rotor_stage dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring),
        .step_in(step_in), .step_out(step_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_sym(in_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_err(out_err),
        .pos(pos), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string ROT [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMQJCFEOK"};
    string NOTCHES = "QEVJZ";

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_w(input int sel, input int dir, input int s);
        if (sel > 4) return s;
        if (dir == 0) return int'(ROT[sel].getc(s)) - 65;
        for (int j = 0; j < 26; j++)
            if (int'(ROT[sel].getc(j)) - 65 == s) return j;
        return -1;
    endfunction

    // {err, sym}
    function automatic logic [5:0] ref_xlat(input int sel, input int pe, input int ring,
                                           input int dir, input int sym);
        int s, w, o;
        if (sym >= 26) return {1'b1, 5'(sym)};
        s = (sym + pe - ring + 52) % 26;
        w = ref_w(sel, dir, s);
        o = (w - pe + ring + 52) % 26;
        return {1'b0, 5'(o)};
    endfunction

    function automatic int ref_notch(input int sel);
        if (sel > 4) return -1;
        return int'(NOTCHES.getc(sel)) - 65;
    endfunction

    task automatic do_cfg(input int sel, input int p, input int r);
        cfg_load = 1'b1; cfg_sel = 3'(sel); cfg_pos = 5'(p); cfg_ring = 5'(r);
        tick();
        cfg_load = 1'b0;
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [4:0] p, ring;
        logic       step, dir;
        logic [4:0] sym, e_out;
        logic       e_err;
        logic [4:0] e_pos;
        logic       e_cerr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic [5:0] q [$];
    logic [5:0] e;
    int m_pos, m_ring, m_sel, m_cerr, m_carry, np;
    int r_sel, r_pos, r_ring;
    logic cl, st, exp_ready;

    initial begin
        rst = 1'b1; cfg_load = 0; cfg_sel = 0; cfg_pos = 0; cfg_ring = 0;
        step_in = 0; in_valid = 0; in_dir = 0; in_sym = 0; out_ready = 1;

        //           sel   pos    ring  step dir  sym    out    err  pos    cerr
        vecs[0] = '{3'd0, 5'd0,  5'd0, 1, 0, 5'd0,  5'd9,  0, 5'd1,  0};
        vecs[1] = '{3'd0, 5'd0,  5'd1, 0, 0, 5'd0,  5'd10, 0, 5'd0,  0};
        vecs[2] = '{3'd0, 5'd0,  5'd1, 0, 1, 5'd10, 5'd0,  0, 5'd0,  0};
        vecs[3] = '{3'd6, 5'd0,  5'd0, 0, 0, 5'd7,  5'd7,  0, 5'd0,  1};
        vecs[4] = '{3'd2, 5'd0,  5'd0, 1, 0, 5'd0,  5'd2,  0, 5'd1,  0};
        vecs[5] = '{3'd0, 5'd5,  5'd0, 0, 0, 5'd30, 5'd30, 1, 5'd5,  0};
        vecs[6] = '{3'd3, 5'd30, 5'd0, 0, 0, 5'd0,  5'd4,  0, 5'd0,  1};
        vecs[7] = '{3'd4, 5'd24, 5'd3, 1, 1, 5'd5,  5'd6,  0, 5'd25, 0};

        // reset state
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_step_out", int'(step_out), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_out_sym", int'(out_sym), 0);
        chk("rst_out_err", int'(out_err), 0);
        #9 rst = 1'b0;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);

        // directed vectors
        for (int i = 0; i < NV; i++) begin
            do_cfg(int'(vecs[i].sel), int'(vecs[i].p), int'(vecs[i].ring));
            step_in = vecs[i].step; in_valid = 1'b1; in_dir = vecs[i].dir; in_sym = vecs[i].sym;
            #1;
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), 1);
            tick();
            step_in = 1'b0; in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d_out_sym", i), int'(out_sym), int'(vecs[i].e_out));
            chk($sformatf("vec%0d_out_err", i), int'(out_err), int'(vecs[i].e_err));
            chk($sformatf("vec%0d_pos", i), int'(pos), int'(vecs[i].e_pos));
            chk($sformatf("vec%0d_cfg_err", i), int'(cfg_err), int'(vecs[i].e_cerr));
        end
        tick();

        // notch carry and wrap
        do_cfg(0, 16, 0);
        step_in = 1; tick(); step_in = 0;
        chk("notchI_pos", int'(pos), 17);
        chk("notchI_carry", int'(step_out), 1);
        tick();
        chk("notchI_carry_one_cycle", int'(step_out), 0);
        do_cfg(0, 25, 0);
        step_in = 1; tick(); step_in = 0;
        chk("wrapI_pos", int'(pos), 0);
        chk("wrapI_no_carry", int'(step_out), 0);
        do_cfg(4, 25, 0);
        step_in = 1; tick(); step_in = 0;
        chk("wrapV_pos", int'(pos), 0);
        chk("wrapV_carry", int'(step_out), 1);

        // cfg_load beats step_in; pos 16 would otherwise carry
        do_cfg(0, 16, 0);
        cfg_load = 1; cfg_sel = 0; cfg_pos = 7; cfg_ring = 0; step_in = 1;
        #1;
        chk("conflict_in_ready", int'(in_ready), 0);
        tick();
        cfg_load = 0; step_in = 0;
        chk("conflict_pos", int'(pos), 7);
        chk("conflict_no_carry", int'(step_out), 0);

        // backpressure
        do_cfg(0, 0, 0);
        out_ready = 0; in_valid = 1; in_dir = 0; in_sym = 3;
        tick();
        chk("bp_valid1", int'(out_valid), 1);
        chk("bp_sym1", int'(out_sym), 5);
        chk("bp_in_ready", int'(in_ready), 0);
        in_sym = 4;
        tick();
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_sym", int'(out_sym), 5);
        out_ready = 1;
        tick();
        in_valid = 0;
        chk("bp_sym2_valid", int'(out_valid), 1);
        chk("bp_sym2", int'(out_sym), 11);
        tick();
        chk("bp_drained", int'(out_valid), 0);

        // async reset with output pending and a carry in flight
        do_cfg(2, 21, 0);
        out_ready = 0; in_valid = 1; in_sym = 0; step_in = 1;
        tick();
        in_valid = 0; step_in = 0;
        chk("ar_pre_valid", int'(out_valid), 1);
        chk("ar_pre_carry", int'(step_out), 1);
        chk("ar_pre_pos", int'(pos), 22);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_carry", int'(step_out), 0);
        chk("ar_pos", int'(pos), 0);
        #1 rst = 1'b0;
        out_ready = 1; in_valid = 1; in_dir = 0; in_sym = 0;
        tick();
        in_valid = 0;
        chk("ar_default_sel_valid", int'(out_valid), 1);
        chk("ar_default_sel_sym", int'(out_sym), 4);
        tick();

        // random traffic against the reference model
        do_cfg(1, 3, 2);
        m_sel = 1; m_pos = 3; m_ring = 2; m_cerr = 0; m_carry = 0;
        for (int c = 0; c < 600; c++) begin
            cl = ($urandom_range(0, 9) == 0);
            r_sel = $urandom_range(0, 7); r_pos = $urandom_range(0, 28); r_ring = $urandom_range(0, 28);
            st = ($urandom_range(0, 2) == 0);
            cfg_load = cl; cfg_sel = 3'(r_sel); cfg_pos = 5'(r_pos); cfg_ring = 5'(r_ring);
            step_in = st;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_dir = 1'($urandom_range(0, 1));
            in_sym = 5'($urandom_range(0, 29));
            #1;
            chk("rnd_pos", int'(pos), m_pos);
            chk("rnd_step_out", int'(step_out), m_carry);
            chk("rnd_cfg_err", int'(cfg_err), m_cerr);
            chk("rnd_out_valid", int'(out_valid), int'(q.size() != 0));
            exp_ready = !cl && (q.size() == 0 || out_ready);
            chk("rnd_in_ready", int'(in_ready), int'(exp_ready));
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_out_sym", int'(out_sym), int'(e[4:0]));
                chk("rnd_out_err", int'(out_err), int'(e[5]));
            end
            np = cl ? m_pos : (st ? (m_pos + 1) % 26 : m_pos);
            if (in_valid && exp_ready)
                q.push_back(ref_xlat(m_sel, np, m_ring, int'(in_dir), int'(in_sym)));
            m_carry = (!cl && st && m_pos == ref_notch(m_sel)) ? 1 : 0;
            if (cl) begin
                m_pos = (r_pos < 26) ? r_pos : 0;
                m_ring = (r_ring < 26) ? r_ring : 0;
                m_sel = r_sel;
                m_cerr = (r_pos >= 26 || r_ring >= 26 || r_sel > 4) ? 1 : 0;
            end else begin
                m_pos = np;
            end
            @(posedge clk);
            #1;
        end

        // drain
        cfg_load = 0; step_in = 0; in_valid = 0; out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("drain_out_sym", int'(out_sym), int'(e[4:0]));
                chk("drain_out_err", int'(out_err), int'(e[5]));
            end
            tick();
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
